// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, imem addressing, stall/wait/redirect handling and IF/ID flush pulse.
// Define FETCH_BHT_EN to add JAL/branch predecode with a 2-bit branch history table predictor.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Write,
    input  logic        EX_Redirect,
    input  logic [63:0] EX_Target,
    input  logic        EX_IsBranch,
    input  logic        EX_Taken,
    input  logic [63:0] EX_BranchPC,
    output logic [63:0] Imem_Addr,
    input  logic [31:0] Imem_Rdata,
    input  logic        Imem_Ready,
    output logic [63:0] IF_PC,
    output logic [31:0] IF_Instruction,
    output logic        IF_Predicted_Taken,
    output logic        Flush
);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    logic        flush_reg;
    logic        pred_taken;
    logic [63:0] pred_target;

    assign Imem_Addr          = pc_reg;
    assign IF_PC              = pc_reg;
    assign IF_Instruction     = Imem_Ready ? Imem_Rdata : NOP_INSN;
    assign IF_Predicted_Taken = pred_taken;
    assign Flush              = flush_reg;

`ifdef FETCH_BHT_EN
    localparam int K = $clog2(BHT_ENTRIES);

    logic [BHT_ENTRIES-1:0][1:0] bht_reg;
    logic [BHT_ENTRIES-1:0][1:0] bht_next;
    logic [K-1:0]                lookup_idx;
    logic [K-1:0]                update_idx;
    logic                        is_jal;
    logic                        is_branch;
    logic [63:0]                 j_imm;
    logic [63:0]                 b_imm;
    logic                        unused_bits;

    assign lookup_idx = pc_reg[K+1:2];
    assign update_idx = EX_BranchPC[K+1:2];
    assign unused_bits = ^{EX_BranchPC[63:K+2], EX_BranchPC[1:0]};

    assign is_jal    = (Imem_Rdata[6:0] == 7'b1101111);
    assign is_branch = (Imem_Rdata[6:0] == 7'b1100011);
    assign j_imm = {{44{Imem_Rdata[31]}}, Imem_Rdata[19:12], Imem_Rdata[20],
                    Imem_Rdata[30:21], 1'b0};
    assign b_imm = {{52{Imem_Rdata[31]}}, Imem_Rdata[7], Imem_Rdata[30:25],
                    Imem_Rdata[11:8], 1'b0};

    // Lookup reads bht_reg, so a same-cycle update to the same entry is not visible yet.
    assign pred_taken  = Imem_Ready && (is_jal || (is_branch && bht_reg[lookup_idx][1]));
    assign pred_target = pc_reg + (is_jal ? j_imm : b_imm);

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic hit;
            assign hit = EX_IsBranch && (update_idx == K'(gi));
            assign bht_next[gi] = !hit     ? bht_reg[gi] :
                                  EX_Taken ? ((bht_reg[gi] == 2'b11) ? 2'b11 : bht_reg[gi] + 2'b01) :
                                             ((bht_reg[gi] == 2'b00) ? 2'b00 : bht_reg[gi] - 2'b01);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bht_reg <= {BHT_ENTRIES{2'b01}};
        end else begin
            bht_reg <= bht_next;
        end
    end
`else
    logic unused_ex;

    assign unused_ex   = ^{EX_IsBranch, EX_Taken, EX_BranchPC};
    assign pred_taken  = 1'b0;
    assign pred_target = pc_reg;
`endif

    // Redirect beats stall and imem wait; a stalled or waiting fetch never advances on a prediction.
    always_comb begin
        pc_next = pc_reg;
        if (EX_Redirect) begin
            pc_next = EX_Target;
        end else if (!PC_Write || !Imem_Ready) begin
            pc_next = pc_reg;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end else begin
            pc_next = pc_reg + 64'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            flush_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            flush_reg <= EX_Redirect;
        end
    end
endmodule
